// File: rtl/ext_cpu_boot_ctrl.sv
// ext_cpu_boot_ctrl: per-hart restart sequencer for the external CPU cluster.
// Each hart runs a small FSM (RUN -> WAIT_SLEEP -> RST/HELD -> RUN). It drives that
// core's active-low local reset and its boot-address select (0 base, 1 wfi).
// Optional feature: define EXT_CPU_BOOT_TIMEOUT_EN to bound the wait for sleep
// with SLEEP_TIMEOUT cycles. A wait that expires is flagged on a sticky timeout_o bit.
module ext_cpu_boot_ctrl #(
    parameter int NHARTS        = 3,
    parameter int RST_CYCLES    = 4,
    parameter int SLEEP_TIMEOUT = 256,
    localparam int HW           = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NHARTS-1:0] sleep_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [HW-1:0]     cmd_hart_i,
    input  logic [1:0]        cmd_op_i,
    output logic [NHARTS-1:0] core_rst_no,
    output logic [NHARTS-1:0] boot_sel_o,
    output logic [NHARTS-1:0] busy_o,
    output logic              cmd_err_o,
    output logic [NHARTS-1:0] timeout_o
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_BASE = 2'b01;
    localparam logic [1:0] OP_WFI  = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
`ifdef EXT_CPU_BOOT_TIMEOUT_EN
    localparam int TW = (SLEEP_TIMEOUT > 1) ? $clog2(SLEEP_TIMEOUT) : 1;
`endif

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_SLEEP = 2'd1,
        ST_RST        = 2'd2,
        ST_HELD       = 2'd3
    } state_e;

    logic [NHARTS-1:0] idle_w;   // hart can take a command (RUN or HELD)
    logic              hart_ok;
    logic              cmd_err_q;

    assign hart_ok   = (int'(cmd_hart_i) < NHARTS);
    assign cmd_err_o = cmd_err_q;

    // Ready: out-of-range targets are always taken (and dropped); otherwise the target must be idle.
    always_comb begin
        cmd_ready_o = 1'b1;
        for (int h = 0; h < NHARTS; h++) begin
            if (int'(cmd_hart_i) == h) cmd_ready_o = idle_w[h];
        end
    end

    // One-cycle error pulse for an accepted command addressed to a nonexistent hart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cmd_err_q <= 1'b0;
        else         cmd_err_q <= cmd_valid_i && cmd_ready_o && !hart_ok;
    end

    for (genvar gi = 0; gi < NHARTS; gi++) begin : g_hart
        state_e        state_q, state_d;
        logic [1:0]    pend_q, pend_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          boot_q, boot_d;
        logic          accept;
        logic          wake;
        logic          restart;
`ifdef EXT_CPU_BOOT_TIMEOUT_EN
        logic [TW-1:0] tcnt_q, tcnt_d;
        logic          tmo_q, tmo_d;
        logic          expired;

        assign expired = (tcnt_q == TW'(SLEEP_TIMEOUT - 1));
        assign wake    = sleep_i[gi] || expired;
`else
        assign wake    = sleep_i[gi];
`endif

        assign accept  = cmd_valid_i && idle_w[gi] && (int'(cmd_hart_i) == gi);
        assign restart = (cmd_op_i == OP_BASE) || (cmd_op_i == OP_WFI);

        // State, pending op, reset-length counter and boot select registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_RUN;
                pend_q  <= OP_NOP;
                cnt_q   <= '0;
                boot_q  <= 1'b0;
`ifdef EXT_CPU_BOOT_TIMEOUT_EN
                tcnt_q  <= '0;
                tmo_q   <= 1'b0;
`endif
            end else begin
                state_q <= state_d;
                pend_q  <= pend_d;
                cnt_q   <= cnt_d;
                boot_q  <= boot_d;
`ifdef EXT_CPU_BOOT_TIMEOUT_EN
                tcnt_q  <= tcnt_d;
                tmo_q   <= tmo_d;
`endif
            end
        end

        // Next-state logic: sleep wait, fixed-length reset pulse, hold, and restart from hold.
        always_comb begin
            state_d = state_q;
            pend_d  = pend_q;
            cnt_d   = cnt_q;
            boot_d  = boot_q;
`ifdef EXT_CPU_BOOT_TIMEOUT_EN
            tcnt_d  = tcnt_q;
            tmo_d   = tmo_q;
            if (accept) tmo_d = 1'b0;
`endif
            unique case (state_q)
                ST_RUN: begin
                    if (accept && cmd_op_i != OP_NOP) begin
                        state_d = ST_WAIT_SLEEP;
                        pend_d  = cmd_op_i;
`ifdef EXT_CPU_BOOT_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end
                end
                ST_WAIT_SLEEP: begin
                    if (wake) begin
                        if (pend_q == OP_HOLD) begin
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_RST;
                            cnt_d   = CW'(RST_CYCLES - 1);
                            boot_d  = (pend_q == OP_WFI);
                        end
`ifdef EXT_CPU_BOOT_TIMEOUT_EN
                        if (!sleep_i[gi]) tmo_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
`endif
                    end
                end
                ST_RST: begin
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ST_HELD: begin
                    // A held core is already asleep in reset, so restart skips the sleep wait.
                    if (accept && restart) begin
                        state_d = ST_RST;
                        pend_d  = cmd_op_i;
                        cnt_d   = CW'(RST_CYCLES - 1);
                        boot_d  = (cmd_op_i == OP_WFI);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        assign idle_w[gi]      = (state_q == ST_RUN) || (state_q == ST_HELD);
        assign core_rst_no[gi] = !((state_q == ST_RST) || (state_q == ST_HELD));
        assign busy_o[gi]      = (state_q == ST_WAIT_SLEEP) || (state_q == ST_RST);
        assign boot_sel_o[gi]  = boot_q;
`ifdef EXT_CPU_BOOT_TIMEOUT_EN
        assign timeout_o[gi]   = tmo_q;
`endif
    end

`ifndef EXT_CPU_BOOT_TIMEOUT_EN
    assign timeout_o = '0;
`endif

endmodule
